hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Next-generation hazard and forwarding controller for the 5-stage MIPS datapath.
- Generates forwarding selects for the EX, ID (branch compare) and MEM (store data) stages.
- Owns all pipeline stall and bubble control: load-use stalls, branch-in-ID stalls, and multi-cycle multiply/divide stalls.
- Forwarding selects are combinational; stalls come from a small FSM with a down-counter.

Parameters:
- REG_AW, 5: register-address width; register 0 is hardwired zero and never forwarded or stalled on.
- MD_LAT, 4: multiply/divide latency in cycles, minimum 2.
- CNT_W, $clog2(MD_LAT+1): stall counter width (derived).

Ports:
- Clk  in  1  pipeline clock
- Rst  in  1  asynchronous, active-high reset
- rs_id, rt_id  in  REG_AW  source registers of the instruction in ID
- use_rt_id  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- branch_id  in  1  ID instruction is a branch compared in ID
- rs_ex, rt_ex, rd_ex  in  REG_AW  sources and destination in ID/EX
- regwrite_ex, memread_ex, md_start_ex  in  1  ID/EX controls
- rd_mem  in  REG_AW  destination in EX/MEM
- regwrite_mem, memread_mem, memwrite_mem  in  1  EX/MEM controls
- rd_wb  in  REG_AW  destination in MEM/WB
- regwrite_wb  in  1  MEM/WB register write enable
- fwd_a_ex, fwd_b_ex  out  2  ALU operand select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
- fwd_a_id, fwd_b_id  out  2  branch comparator select, same encoding
- fwd_store_mem  out  1  store data taken from MEM/WB result
- stall_pc, stall_ifid  out  1  hold PC and the IF/ID register
- bubble_idex  out  1  zero the ID/EX control bits on the next edge
- md_busy  out  1  multi-cycle unit occupied

Behaviour:
- Match terms:
  - mem_hit(r) = regwrite_mem && rd_mem != 0 && rd_mem == r.
  - wb_hit(r) = regwrite_wb && rd_wb != 0 && rd_wb == r.
- EX forwarding, per operand:
  - 10 if mem_hit, else 01 if wb_hit, else 00.
  - MEM has strict priority over WB.
- ID forwarding (fwd_*_id):
  - Evaluated only when branch_id; otherwise 00.
  - 10 if mem_hit && !memread_mem, else 01 if wb_hit, else 00.
- fwd_store_mem = memwrite_mem && wb_hit(rd_mem). Here rd_mem carries the store's rt.
- Hazard terms, combinational on ID inputs:
  - dep_ex = regwrite_ex && rd_ex != 0 && (rd_ex == rs_id || (use_rt_id && rd_ex == rt_id)).
  - dep_mem is the same expression using the MEM-stage signals.
- Stall need N:
  - branch_id && dep_ex && memread_ex: 2.
  - memread_ex && dep_ex: 1.
  - branch_id && dep_ex: 1.
  - branch_id && dep_mem && memread_mem: 1.
  - Otherwise 0.
- FSM states: RUN, HOLD, MD_BUSY. cnt is CNT_W bits.
- RUN:
  - If md_start_ex: go to MD_BUSY, cnt <= MD_LAT-1; assert stall_pc, stall_ifid and bubble_idex this cycle.
  - Else if N != 0: stall_pc = stall_ifid = bubble_idex = 1 this cycle. If N == 2, go to HOLD with cnt <= 1; else stay in RUN.
  - Else no stall.
- HOLD:
  - All three stall outputs are 1.
  - cnt decrements each cycle; at cnt == 1 the next state is RUN.
  - md_start_ex is ignored, since ID/EX is a bubble.
- MD_BUSY:
  - md_busy = 1; stall_pc = stall_ifid = bubble_idex = 1.
  - cnt decrements; when cnt reaches 1 the next state is RUN.
  - Total front-end stall is exactly MD_LAT cycles, counting the entry cycle in RUN.
- Simultaneous events:
  - md_start_ex wins over any N in the same cycle.
  - N is re-evaluated on return to RUN; a pending hazard then stalls again.
- Forwarding outputs stay live in every state.
- Reset: state = RUN, cnt = 0, md_busy = 0.
  - All stall and bubble outputs deassert immediately, including mid-HOLD or mid-MD_BUSY.
  - fwd_* follow their inputs combinationally; they are 0 if the pipeline-register inputs are 0.
- cnt never underflows. Any illegal state encoding recovers to RUN.

Decomposition:
- Shared package mips_pipe_pkg:
  - fwd_sel_t encoding constants: FWD_RF = 00, FWD_MEM = 10, FWD_WB = 01.
  - hz_state_t: RUN, HOLD, MD_BUSY.
- One sub-module, fwd_match: given (rd, regwrite, r), returns the hit bit. It is instantiated for each match term.

Test Plan:
- EX priority: rd_mem = rd_wb = 8, both regwrite, rs_ex = 8 -> fwd_a_ex = 10. Then rd_mem = 0 -> 01.
- Load-use: memread_ex = 1, rd_ex = 9, rt_id = 9, use_rt_id = 1 -> exactly one cycle of stall_pc, stall_ifid and bubble_idex; the next cycle has no stall; fwd_b_ex = 10 afterwards is not applicable because it is a load, so the WB path shows 01 two cycles later.
- Branch after load: branch_id = 1, rs_id = 4, lw to $4 in EX -> 2 stall cycles (RUN then HOLD). Then fwd_a_id = 01 while the load is in WB.
- Multi-cycle op, MD_LAT = 4: md_start_ex pulse -> md_busy high for cycles 2-4 and stalls high for cycles 1-4. Assert Rst in cycle 3 -> all stalls and md_busy drop the same cycle.
- Register zero and store forwarding: rd_mem = 0 with all hits -> all selects 00, no stall. memwrite_mem = 1, rd_mem = rd_wb = 12, regwrite_wb = 1 -> fwd_store_mem = 1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline hazard/forwarding logic:
// forwarding-select encodings, hazard FSM states and a select helper.
package mips_pipe_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        MD_BUSY = 2'd2
    } hz_state_t;

    // The younger producer (EX/MEM) always wins over MEM/WB.
    function automatic fwd_sel_t fwd_pick(input logic mem_ok, input logic wb_ok);
        if (mem_ok)
            return FWD_MEM;
        else if (wb_ok)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// One register match term: the stage writes a non-zero destination equal to r.
module fwd_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rd,
    input  logic              regwrite,
    input  logic [REG_AW-1:0] r,
    output logic              hit
);

    // Register 0 is hardwired zero, so it never matches.
    assign hit = regwrite && (rd != '0) && (rd == r);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS datapath.
// Forwarding selects are purely combinational; stall/bubble control comes
// from a RUN/HOLD/MD_BUSY FSM with a small down-counter.
//
// Stall handshake: stall_pc and stall_ifid hold the front end for every cycle
// they are high; bubble_idex is high in exactly the same cycles and zeroes the
// ID/EX control bits on the following edge. There is no ready/acknowledge.
module hazard_forward_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              use_rt_id,
    input  logic              branch_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              regwrite_ex,
    input  logic              memread_ex,
    input  logic              md_start_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              regwrite_mem,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              regwrite_wb,
    output logic [1:0]        fwd_a_ex,
    output logic [1:0]        fwd_b_ex,
    output logic [1:0]        fwd_a_id,
    output logic [1:0]        fwd_b_id,
    output logic              fwd_store_mem,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              md_busy,
    output hz_state_t         dbg_state
);

    // Source order: 0 = rs_ex, 1 = rt_ex, 2 = rs_id, 3 = rt_id.
    logic [REG_AW-1:0] src [4];
    logic [3:0]        mem_hit;
    logic [3:0]        wb_hit;
    logic              ex_hit_rs;
    logic              ex_hit_rt;
    logic              store_wb_hit;

    assign src[0] = rs_ex;
    assign src[1] = rt_ex;
    assign src[2] = rs_id;
    assign src[3] = rt_id;

    for (genvar i = 0; i < 4; i++) begin : g_hit
        fwd_match #(.REG_AW(REG_AW)) u_mem (
            .rd(rd_mem), .regwrite(regwrite_mem), .r(src[i]), .hit(mem_hit[i])
        );
        fwd_match #(.REG_AW(REG_AW)) u_wb (
            .rd(rd_wb), .regwrite(regwrite_wb), .r(src[i]), .hit(wb_hit[i])
        );
    end

    fwd_match #(.REG_AW(REG_AW)) u_ex_rs (
        .rd(rd_ex), .regwrite(regwrite_ex), .r(rs_id), .hit(ex_hit_rs)
    );
    fwd_match #(.REG_AW(REG_AW)) u_ex_rt (
        .rd(rd_ex), .regwrite(regwrite_ex), .r(rt_id), .hit(ex_hit_rt)
    );
    // For a store in MEM, rd_mem carries the store's rt register.
    fwd_match #(.REG_AW(REG_AW)) u_store (
        .rd(rd_wb), .regwrite(regwrite_wb), .r(rd_mem), .hit(store_wb_hit)
    );

    // Forwarding selects; a load in MEM has no data yet for the ID comparator.
    always_comb begin
        fwd_a_ex      = fwd_pick(mem_hit[0], wb_hit[0]);
        fwd_b_ex      = fwd_pick(mem_hit[1], wb_hit[1]);
        fwd_a_id      = FWD_RF;
        fwd_b_id      = FWD_RF;
        if (branch_id) begin
            fwd_a_id = fwd_pick(mem_hit[2] && !memread_mem, wb_hit[2]);
            fwd_b_id = fwd_pick(mem_hit[3] && !memread_mem, wb_hit[3]);
        end
        fwd_store_mem = memwrite_mem && store_wb_hit;
    end

    logic       dep_ex;
    logic       dep_mem;
    logic [1:0] need;

    // Number of stall cycles the ID instruction needs right now.
    always_comb begin
        dep_ex  = ex_hit_rs || (use_rt_id && ex_hit_rt);
        dep_mem = mem_hit[2] || (use_rt_id && mem_hit[3]);
        need    = 2'd0;
        if (branch_id && dep_ex && memread_ex)
            need = 2'd2;
        else if (memread_ex && dep_ex)
            need = 2'd1;
        else if (branch_id && dep_ex)
            need = 2'd1;
        else if (branch_id && dep_mem && memread_mem)
            need = 2'd1;
    end

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_any;
    logic             busy_any;

    // Next state, counter and stall decode; md_start_ex beats any hazard.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_any = 1'b0;
        busy_any  = 1'b0;
        case (state_q)
            RUN: begin
                if (md_start_ex) begin
                    stall_any = 1'b1;
                    state_d   = MD_BUSY;
                    cnt_d     = CNT_W'(MD_LAT - 1);
                end else if (need != 2'd0) begin
                    stall_any = 1'b1;
                    if (need == 2'd2) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            HOLD, MD_BUSY: begin
                stall_any = 1'b1;
                busy_any  = (state_q == MD_BUSY);
                // Counting down to 1 ends the stall; 0 is only a safety net.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset drops all stall outputs at once, even while a hazard is present.
    assign stall_pc    = stall_any && !rst;
    assign stall_ifid  = stall_any && !rst;
    assign bubble_idex = stall_any && !rst;
    assign md_busy     = busy_any && !rst;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: vector table, hand-written pipeline
// sequences, and random stimulus against a stall-budget reference model.
module tb_hazard_forward_ctrl;
    import mips_pipe_pkg::*;

    localparam int MD_LAT = 4;

    logic       clk, rst;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
    logic       use_rt_id, branch_id;
    logic       regwrite_ex, memread_ex, md_start_ex;
    logic       regwrite_mem, memread_mem, memwrite_mem, regwrite_wb;
    logic [1:0] fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id;
    logic       fwd_store_mem, stall_pc, stall_ifid, bubble_idex, md_busy;
    hz_state_t  dbg_state;

    int total = 0;
    int bad   = 0;

    hazard_forward_ctrl #(.REG_AW(5), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst(rst),
        .rs_id(rs_id), .rt_id(rt_id), .use_rt_id(use_rt_id), .branch_id(branch_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .md_start_ex(md_start_ex),
        .rd_mem(rd_mem), .regwrite_mem(regwrite_mem), .memread_mem(memread_mem),
        .memwrite_mem(memwrite_mem), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
        .fwd_store_mem(fwd_store_mem), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .bubble_idex(bubble_idex), .md_busy(md_busy), .dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_stall(input string name, input logic exp_stall, input logic exp_busy);
        check({name, "_stall_pc"}, {7'd0, stall_pc}, {7'd0, exp_stall});
        check({name, "_stall_ifid"}, {7'd0, stall_ifid}, {7'd0, exp_stall});
        check({name, "_bubble"}, {7'd0, bubble_idex}, {7'd0, exp_stall});
        check({name, "_md_busy"}, {7'd0, md_busy}, {7'd0, exp_busy});
    endtask

    task automatic clear_inputs();
        rs_id = 0; rt_id = 0; use_rt_id = 0; branch_id = 0;
        rs_ex = 0; rt_ex = 0; rd_ex = 0;
        regwrite_ex = 0; memread_ex = 0; md_start_ex = 0;
        rd_mem = 0; regwrite_mem = 0; memread_mem = 0; memwrite_mem = 0;
        rd_wb = 0; regwrite_wb = 0;
    endtask

    // Inputs change just after the rising edge; checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return we && (rd != 0) && (rd == r);
    endfunction

    function automatic logic [1:0] sel(input logic m, input logic w);
        return m ? 2'b10 : (w ? 2'b01 : 2'b00);
    endfunction

    function automatic int need_cycles();
        logic dex, dmem;
        dex  = hit(regwrite_ex, rd_ex, rs_id) || (use_rt_id && hit(regwrite_ex, rd_ex, rt_id));
        dmem = hit(regwrite_mem, rd_mem, rs_id) || (use_rt_id && hit(regwrite_mem, rd_mem, rt_id));
        if (branch_id && dex && memread_ex) return 2;
        if (memread_ex && dex) return 1;
        if (branch_id && dex) return 1;
        if (branch_id && dmem && memread_mem) return 1;
        return 0;
    endfunction

    // Remaining stall cycles after the current one, and whether they belong to a mul/div.
    int stall_left = 0;
    bit md_mode    = 0;

    typedef struct {
        logic [4:0] rs_ex, rt_ex, rd_mem;
        logic       rwm, mrm, mwm;
        logic [4:0] rd_wb;
        logic       rwb, br;
        logic [4:0] rs_id, rt_id;
        logic [1:0] a_ex, b_ex, a_id, b_id;
        logic       st, stl;
    } vec_t;

    vec_t vecs [11];

    initial begin
        rst = 1'b0;
        clear_inputs();

        vecs[0]  = '{5'd8,  5'd0, 5'd8,  1'b1, 1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 5'd0, 5'd0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{5'd8,  5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 5'd0, 5'd0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{5'd3,  5'd5, 5'd5,  1'b1, 1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 5'd0, 5'd0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{5'd5,  5'd5, 5'd5,  1'b0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0, 5'd0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{5'd0,  5'd0, 5'd6,  1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 5'd6, 5'd7, 2'b00, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0};
        vecs[5]  = '{5'd0,  5'd0, 5'd6,  1'b1, 1'b1, 1'b0, 5'd6,  1'b1, 1'b1, 5'd6, 5'd0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1};
        vecs[6]  = '{5'd0,  5'd0, 5'd6,  1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 5'd6, 5'd7, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{5'd12, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[9]  = '{5'd12, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{5'd9,  5'd0, 5'd9,  1'b1, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 5'd1, 5'd9, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};

        // Reset state.
        do_reset();
        @(negedge clk);
        check("reset_state", {6'd0, dbg_state}, {6'd0, RUN});
        check_stall("reset", 1'b0, 1'b0);
        check("reset_fwd", {fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id}, 8'h00);
        check("reset_store", {7'd0, fwd_store_mem}, 8'h00);

        // Vector table: forwarding, priority, register zero, store data.
        for (int i = 0; i < 11; i++) begin
            tick();
            clear_inputs();
            use_rt_id = 1'b1;
            rs_ex = vecs[i].rs_ex; rt_ex = vecs[i].rt_ex; rd_mem = vecs[i].rd_mem;
            regwrite_mem = vecs[i].rwm; memread_mem = vecs[i].mrm; memwrite_mem = vecs[i].mwm;
            rd_wb = vecs[i].rd_wb; regwrite_wb = vecs[i].rwb; branch_id = vecs[i].br;
            rs_id = vecs[i].rs_id; rt_id = vecs[i].rt_id;
            @(negedge clk);
            check($sformatf("vec%0d_a_ex", i), {6'd0, fwd_a_ex}, {6'd0, vecs[i].a_ex});
            check($sformatf("vec%0d_b_ex", i), {6'd0, fwd_b_ex}, {6'd0, vecs[i].b_ex});
            check($sformatf("vec%0d_a_id", i), {6'd0, fwd_a_id}, {6'd0, vecs[i].a_id});
            check($sformatf("vec%0d_b_id", i), {6'd0, fwd_b_id}, {6'd0, vecs[i].b_id});
            check($sformatf("vec%0d_store", i), {7'd0, fwd_store_mem}, {7'd0, vecs[i].st});
            check($sformatf("vec%0d_stall", i), {7'd0, stall_pc}, {7'd0, vecs[i].stl});
        end

        // Load-use: one stall cycle, then the load forwards from WB.
        tick();
        clear_inputs();
        memread_ex = 1; regwrite_ex = 1; rd_ex = 9; rt_id = 9; use_rt_id = 1; rs_id = 2;
        @(negedge clk);
        check_stall("lu_c1", 1'b1, 1'b0);
        tick();
        clear_inputs();
        rt_id = 9; use_rt_id = 1; rs_id = 2;
        rd_mem = 9; regwrite_mem = 1; memread_mem = 1;
        @(negedge clk);
        check_stall("lu_c2", 1'b0, 1'b0);
        check("lu_c2_state", {6'd0, dbg_state}, {6'd0, RUN});
        tick();
        clear_inputs();
        rt_ex = 9; rs_ex = 2; rd_wb = 9; regwrite_wb = 1;
        @(negedge clk);
        check("lu_fwd_b_ex", {6'd0, fwd_b_ex}, 8'h01);
        check("lu_fwd_a_ex", {6'd0, fwd_a_ex}, 8'h00);

        // Branch after a load: two stall cycles, then compare forwarded from WB.
        tick();
        clear_inputs();
        branch_id = 1; rs_id = 4; rd_ex = 4; regwrite_ex = 1; memread_ex = 1;
        @(negedge clk);
        check_stall("br_c1", 1'b1, 1'b0);
        check("br_c1_state", {6'd0, dbg_state}, {6'd0, RUN});
        tick();
        clear_inputs();
        branch_id = 1; rs_id = 4; rd_mem = 4; regwrite_mem = 1; memread_mem = 1;
        @(negedge clk);
        check_stall("br_c2", 1'b1, 1'b0);
        check("br_c2_state", {6'd0, dbg_state}, {6'd0, HOLD});
        tick();
        clear_inputs();
        branch_id = 1; rs_id = 4; rd_wb = 4; regwrite_wb = 1;
        @(negedge clk);
        check_stall("br_c3", 1'b0, 1'b0);
        check("br_fwd_a_id", {6'd0, fwd_a_id}, 8'h01);

        // Mul/div: stalls for MD_LAT cycles, busy from the second cycle on.
        tick();
        clear_inputs();
        md_start_ex = 1;
        for (int c = 1; c <= MD_LAT + 1; c++) begin
            @(negedge clk);
            check_stall($sformatf("md_c%0d", c), c <= MD_LAT, (c >= 2) && (c <= MD_LAT));
            tick();
            md_start_ex = 0;
        end

        // Mul/div interrupted by reset in cycle 3; a hazard during reset must not stall.
        clear_inputs();
        md_start_ex = 1;
        tick();
        md_start_ex = 0;
        tick();
        check_stall("mdr_c3_pre", 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check_stall("mdr_c3_rst", 1'b0, 1'b0);
        check("mdr_state", {6'd0, dbg_state}, {6'd0, RUN});
        memread_ex = 1; regwrite_ex = 1; rd_ex = 9; rt_id = 9; use_rt_id = 1;
        #1;
        check_stall("mdr_rst_hazard", 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check_stall("mdr_after", 1'b0, 1'b0);

        // md_start_ex wins over a pending load-use; the hazard stalls again afterwards.
        tick();
        clear_inputs();
        md_start_ex = 1; memread_ex = 1; regwrite_ex = 1; rd_ex = 7; rs_id = 7;
        @(negedge clk);
        check_stall("mdw_c1", 1'b1, 1'b0);
        tick();
        md_start_ex = 0;
        @(negedge clk);
        check("mdw_c2_state", {6'd0, dbg_state}, {6'd0, MD_BUSY});
        repeat (MD_LAT - 1) tick();
        @(negedge clk);
        check("mdw_c5_state", {6'd0, dbg_state}, {6'd0, RUN});
        check_stall("mdw_c5", 1'b1, 1'b0);

        // Random traffic against the reference model.
        tick();
        clear_inputs();
        do_reset();
        stall_left = 0;
        md_mode    = 0;
        for (int i = 0; i < 600; i++) begin
            logic       exp_stall, exp_busy;
            logic [1:0] exp_a_id, exp_b_id;
            hz_state_t  exp_state;
            int         n;
            rs_id = 5'($urandom_range(0, 3)); rt_id = 5'($urandom_range(0, 3));
            rs_ex = 5'($urandom_range(0, 3)); rt_ex = 5'($urandom_range(0, 3));
            rd_ex = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
            rd_wb = 5'($urandom_range(0, 3));
            use_rt_id = 1'($urandom_range(0, 1)); branch_id = 1'($urandom_range(0, 1));
            regwrite_ex = 1'($urandom_range(0, 1)); memread_ex = 1'($urandom_range(0, 1));
            md_start_ex = ($urandom_range(0, 9) == 0);
            regwrite_mem = 1'($urandom_range(0, 1)); memread_mem = 1'($urandom_range(0, 1));
            memwrite_mem = 1'($urandom_range(0, 1)); regwrite_wb = 1'($urandom_range(0, 1));
            @(negedge clk);
            n = need_cycles();
            if (stall_left > 0) begin
                exp_stall = 1'b1;
                exp_busy  = md_mode;
                exp_state = md_mode ? MD_BUSY : HOLD;
            end else begin
                exp_stall = md_start_ex || (n != 0);
                exp_busy  = 1'b0;
                exp_state = RUN;
            end
            exp_a_id = branch_id ? sel(hit(regwrite_mem, rd_mem, rs_id) && !memread_mem,
                                       hit(regwrite_wb, rd_wb, rs_id)) : 2'b00;
            exp_b_id = branch_id ? sel(hit(regwrite_mem, rd_mem, rt_id) && !memread_mem,
                                       hit(regwrite_wb, rd_wb, rt_id)) : 2'b00;
            check($sformatf("rnd%0d_a_ex", i), {6'd0, fwd_a_ex},
                  {6'd0, sel(hit(regwrite_mem, rd_mem, rs_ex), hit(regwrite_wb, rd_wb, rs_ex))});
            check($sformatf("rnd%0d_b_ex", i), {6'd0, fwd_b_ex},
                  {6'd0, sel(hit(regwrite_mem, rd_mem, rt_ex), hit(regwrite_wb, rd_wb, rt_ex))});
            check($sformatf("rnd%0d_id", i), {4'd0, fwd_a_id, fwd_b_id}, {4'd0, exp_a_id, exp_b_id});
            check($sformatf("rnd%0d_store", i), {7'd0, fwd_store_mem},
                  {7'd0, memwrite_mem && hit(regwrite_wb, rd_wb, rd_mem)});
            check_stall($sformatf("rnd%0d", i), exp_stall, exp_busy);
            check($sformatf("rnd%0d_state", i), {6'd0, dbg_state}, {6'd0, exp_state});
            // Advance the model across the coming edge.
            if (stall_left > 0) begin
                stall_left--;
            end else if (md_start_ex) begin
                stall_left = MD_LAT - 1;
                md_mode    = 1;
            end else if (n == 2) begin
                stall_left = 1;
                md_mode    = 0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
